multicycle_control_unit: RTL and testbench

Multicycle control FSM for the RV64I core: sequences fetch, decode, execute, memory and write-back over a shared datapath (PC, IR, register file, ALU, immediate extender, memory ports). It drives all datapath enables and mux selects from the registered instruction fields and handles the instruction- and data-memory handshakes. It detects illegal encodings and halts on them.

---
 rtl/instruction_pkg.sv | 60 ++++++
 rtl/multicycle_control_unit_decoder.sv | 46 ++++
 rtl/multicycle_control_unit.sv | 140 ++++++++++++++
 tb/tb_multicycle_control_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_pkg.sv
// Shared encodings for the RV64I multicycle core: opcodes, controller states,
// datapath select codes and the per-class ALU control helper.
package instruction_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD      = 7'b0000011,
    OPC_MISC_MEM  = 7'b0001111,
    OPC_OP_IMM    = 7'b0010011,
    OPC_AUIPC     = 7'b0010111,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_STORE     = 7'b0100011,
    OPC_OP        = 7'b0110011,
    OPC_LUI       = 7'b0110111,
    OPC_OP_32     = 7'b0111011,
    OPC_BRANCH    = 7'b1100011,
    OPC_JALR      = 7'b1100111,
    OPC_JAL       = 7'b1101111,
    OPC_SYSTEM    = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK, ST_HALT
  } ctrl_state_t;

  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_JALR = 2'd2} pc_src_t;
  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_src_a_t;
  typedef enum logic [1:0] {WR_ALU = 2'd0, WR_MDR = 2'd1, WR_PC4 = 2'd2} wr_reg_src_t;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_FUNCT = 2'd1, ALU_CMP = 2'd2} alu_op_t;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_ALU_R, CLS_ALU_RW, CLS_ALU_I, CLS_ALU_IW, CLS_LUI, CLS_AUIPC,
    CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_FENCE, CLS_SYSTEM
  } inst_class_t;

  typedef struct packed {
    alu_src_a_t src_a;
    logic       src_b;
    alu_op_t    op;
    logic       w32;
  } alu_ctrl_t;

  // ALU selects are a pure function of the class and are held from Execute
  // through WriteBack.
  function automatic alu_ctrl_t alu_ctrl(inst_class_t c);
    alu_ctrl_t a;
    a = '0;
    case (c)
      CLS_ALU_R:  a.op = ALU_FUNCT;
      CLS_ALU_RW: begin a.op = ALU_FUNCT; a.w32 = 1'b1; end
      CLS_ALU_I:  begin a.src_b = 1'b1; a.op = ALU_FUNCT; end
      CLS_ALU_IW: begin a.src_b = 1'b1; a.op = ALU_FUNCT; a.w32 = 1'b1; end
      CLS_LUI:    begin a.src_a = A_ZERO; a.src_b = 1'b1; end
      CLS_AUIPC:  begin a.src_a = A_PC; a.src_b = 1'b1; end
      CLS_LOAD, CLS_STORE: a.src_b = 1'b1;
      default: ;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational instruction classifier: maps opcode/funct3/funct7 to an
// instruction class and flags reserved encodings.
module control_decoder
  import instruction_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output inst_class_t class_o,
  output logic        illegal_o
);

  logic is_shift;
  logic f7_ok;
  logic shamt_hi;

  assign is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);
  assign f7_ok    = (funct7_i == 7'b0000000) || (funct7_i == 7'b0100000);
  // IR[25] is shamt bit 5, only meaningful for 64-bit shifts.
  assign shamt_hi = is_shift && funct7_i[0];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    class_o   = CLS_NONE;
    illegal_o = 1'b0;
    case (opcode_t'(opcode_i))
      OPC_OP:        begin class_o = CLS_ALU_R;  illegal_o = !f7_ok; end
      OPC_OP_32:     begin class_o = CLS_ALU_RW; illegal_o = !f7_ok; end
      OPC_OP_IMM:    begin class_o = CLS_ALU_I;  illegal_o = (N == 32) && shamt_hi; end
      OPC_OP_IMM_32: begin class_o = CLS_ALU_IW; illegal_o = shamt_hi; end
      OPC_LUI:       class_o = CLS_LUI;
      OPC_AUIPC:     class_o = CLS_AUIPC;
      OPC_LOAD:      begin class_o = CLS_LOAD;   illegal_o = (funct3_i == 3'b111); end
      OPC_STORE:     begin class_o = CLS_STORE;  illegal_o = funct3_i[2]; end
      OPC_BRANCH:    begin class_o = CLS_BRANCH; illegal_o = (funct3_i[2:1] == 2'b01); end
      OPC_JAL:       class_o = CLS_JAL;
      OPC_JALR:      begin class_o = CLS_JALR;   illegal_o = (funct3_i != 3'b000); end
      OPC_MISC_MEM:  class_o = CLS_FENCE;
      OPC_SYSTEM:    class_o = CLS_SYSTEM;
      default:       illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV64I controller: Fetch/Decode/Execute/Memory/WriteBack sequencing
// with registered datapath controls and handshake-qualified strobes.
module multicycle_control_unit
  import instruction_pkg::*;
#(
  parameter int N = 64
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       inst_mem_ack_i,
  input  logic       data_mem_ack_i,
  input  logic       cond_true_i,
  output logic       inst_mem_en_o,
  output logic       ir_en_o,
  output logic       pc_en_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] alu_src_a_o,
  output logic       alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       alu_32b_o,
  output logic       data_mem_rd_en_o,
  output logic       data_mem_wr_en_o,
  output logic       mdr_en_o,
  output logic       wr_reg_en_o,
  output logic [1:0] wr_reg_src_o,
  output logic       illegal_instruction_o,
  output logic       halted_o
);

  ctrl_state_t state_q, state_d;
  inst_class_t class_q, class_d;
  inst_class_t dec_class;
  logic        dec_illegal;

  logic        inst_req_q, rd_req_q, wr_req_q;
  logic        pc_en_q, branch_q, wr_reg_en_q;
  pc_src_t     pc_src_q;
  wr_reg_src_t wr_reg_src_q;
  alu_ctrl_t   alu_q;
  logic        illegal_q, halted_q;

  logic to_exec, to_mem, to_wb, jump_d, run;

  control_decoder #(.N(N)) u_decoder (
    .opcode_i  (opcode_i),
    .funct3_i  (funct3_i),
    .funct7_i  (funct7_i),
    .class_o   (dec_class),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (inst_mem_ack_i) state_d = ST_DECODE;
      ST_DECODE: begin
        class_d = dec_class;
        state_d = (dec_illegal || dec_class == CLS_SYSTEM) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (class_q)
          CLS_LOAD, CLS_STORE:                      state_d = ST_MEMORY;
          CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_FENCE: state_d = ST_FETCH;
          default:                                  state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY:    if (data_mem_ack_i) state_d = (class_q == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign to_exec = (state_d == ST_EXECUTE);
  assign to_mem  = (state_d == ST_MEMORY);
  assign to_wb   = (state_d == ST_WRITEBACK);
  assign jump_d  = (class_d == CLS_JAL) || (class_d == CLS_JALR);

  // Outputs are registered from the state being entered, so they are glitch-free
  // for the whole state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      class_q      <= CLS_NONE;
      inst_req_q   <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      pc_en_q      <= 1'b0;
      branch_q     <= 1'b0;
      wr_reg_en_q  <= 1'b0;
      pc_src_q     <= PC_PLUS4;
      wr_reg_src_q <= WR_ALU;
      alu_q        <= '0;
      illegal_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q      <= state_d;
      class_q      <= class_d;
      inst_req_q   <= (state_d == ST_FETCH);
      rd_req_q     <= to_mem && (class_d == CLS_LOAD);
      wr_req_q     <= to_mem && (class_d == CLS_STORE);
      pc_en_q      <= to_wb || (to_exec && (jump_d || class_d == CLS_BRANCH || class_d == CLS_FENCE));
      branch_q     <= to_exec && (class_d == CLS_BRANCH);
      wr_reg_en_q  <= to_wb || (to_exec && jump_d);
      pc_src_q     <= (to_exec && class_d == CLS_JAL)  ? PC_IMM  :
                      (to_exec && class_d == CLS_JALR) ? PC_JALR : PC_PLUS4;
      wr_reg_src_q <= (to_exec && jump_d) ? WR_PC4 :
                      (to_wb && class_d == CLS_LOAD) ? WR_MDR : WR_ALU;
      alu_q        <= (to_exec || to_mem || to_wb) ? alu_ctrl(class_d) : '0;
      illegal_q    <= illegal_q || (state_q == ST_DECODE && dec_illegal);
      halted_q     <= (state_d == ST_HALT);
    end
  end

  // Ack-qualified strobes and the branch target are combinational; reset masks
  // every enable in the cycle it is asserted.
  assign run              = !reset_i;
  assign inst_mem_en_o    = inst_req_q & run;
  assign ir_en_o          = inst_req_q & inst_mem_ack_i & run;
  assign data_mem_rd_en_o = rd_req_q & run;
  assign data_mem_wr_en_o = wr_req_q & run;
  assign mdr_en_o         = rd_req_q & data_mem_ack_i & run;
  assign pc_en_o          = (pc_en_q | (wr_req_q & data_mem_ack_i)) & run;
  assign wr_reg_en_o      = wr_reg_en_q & run;
  assign pc_src_o         = branch_q ? {1'b0, cond_true_i} : pc_src_q;
  assign wr_reg_src_o     = wr_reg_src_q;
  assign alu_src_a_o      = alu_q.src_a;
  assign alu_src_b_o      = alu_q.src_b;
  assign alu_op_o         = alu_q.op;
  assign alu_32b_o        = alu_q.w32;
  assign illegal_instruction_o = illegal_q;
  assign halted_o         = halted_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: per-instruction summaries are
// compared against a latency/enable model derived from the instruction rules.
module tb_multicycle_control_unit;

  localparam int DUT_N = 64;

  logic clk, rst;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic iack, dack, cond;
  logic inst_mem_en_o, ir_en_o, pc_en_o, alu_src_b_o, alu_32b_o;
  logic data_mem_rd_en_o, data_mem_wr_en_o, mdr_en_o, wr_reg_en_o;
  logic illegal_instruction_o, halted_o;
  logic [1:0] pc_src_o, alu_src_a_o, alu_op_o, wr_reg_src_o;
  logic [6:0] en_bus;

  multicycle_control_unit #(.N(DUT_N)) dut (
    .clock_i(clk), .reset_i(rst), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .inst_mem_ack_i(iack), .data_mem_ack_i(dack), .cond_true_i(cond),
    .inst_mem_en_o(inst_mem_en_o), .ir_en_o(ir_en_o), .pc_en_o(pc_en_o), .pc_src_o(pc_src_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .alu_32b_o(alu_32b_o), .data_mem_rd_en_o(data_mem_rd_en_o),
    .data_mem_wr_en_o(data_mem_wr_en_o), .mdr_en_o(mdr_en_o), .wr_reg_en_o(wr_reg_en_o),
    .wr_reg_src_o(wr_reg_src_o), .illegal_instruction_o(illegal_instruction_o),
    .halted_o(halted_o)
  );

  assign en_bus = {inst_mem_en_o, ir_en_o, pc_en_o, data_mem_rd_en_o,
                   data_mem_wr_en_o, mdr_en_o, wr_reg_en_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    bit halts; bit illegal; int base; int mem; bit writes;
    int wsrc; int pcsrc; int a; int b; int op; int w;
  } exp_t;

  // Expected behaviour of one instruction from the ISA rules.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input bit cnd);
    exp_t e;
    bit r_ok, shift;
    e = '{default: 0};
    r_ok  = (f7 == 7'h00) || (f7 == 7'h20);
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    case (op)
      7'b0110011: begin e.base = 4; e.writes = 1; e.op = 1; e.illegal = !r_ok; end
      7'b0111011: begin e.base = 4; e.writes = 1; e.op = 1; e.w = 1; e.illegal = !r_ok; end
      7'b0010011: begin e.base = 4; e.writes = 1; e.b = 1; e.op = 1;
                        e.illegal = (DUT_N == 32) && shift && f7[0]; end
      7'b0011011: begin e.base = 4; e.writes = 1; e.b = 1; e.op = 1; e.w = 1;
                        e.illegal = shift && f7[0]; end
      7'b0110111: begin e.base = 4; e.writes = 1; e.a = 2; e.b = 1; end
      7'b0010111: begin e.base = 4; e.writes = 1; e.a = 1; e.b = 1; end
      7'b0000011: begin e.base = 5; e.mem = 1; e.writes = 1; e.wsrc = 1; e.b = 1;
                        e.illegal = (f3 == 3'd7); end
      7'b0100011: begin e.base = 4; e.mem = 2; e.b = 1; e.illegal = (f3 > 3'd3); end
      7'b1100011: begin e.base = 3; e.pcsrc = int'(cnd); e.illegal = (f3 == 3'd2) || (f3 == 3'd3); end
      7'b1101111: begin e.base = 3; e.writes = 1; e.wsrc = 2; e.pcsrc = 1; end
      7'b1100111: begin e.base = 3; e.writes = 1; e.wsrc = 2; e.pcsrc = 2; e.illegal = (f3 != 3'd0); end
      7'b0001111: e.base = 3;
      7'b1110011: e.halts = 1;
      default:    e.illegal = 1;
    endcase
    if (e.illegal) e.halts = 1;
    return e;
  endfunction

  // Runs one instruction starting at the negedge of its Fetch-entry cycle and
  // returns at the negedge of the next Fetch entry or once halted.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int wi, input int wd, input bit cnd);
    exp_t e;
    int n = 0, icnt = 0, dcnt = 0, ir_c = 0, pc_c = 0, wr_c = 0, both_c = 0;
    int mdr_c = 0, rd_c = 0, st_c = 0, pcs = -1, wrs = -1, a = -1, b = -1, o = -1, w = -1;
    bit prev_ie = 0;
    e = model(op, f3, f7, cnd);
    opcode = op; funct3 = f3; funct7 = f7; cond = cnd;
    forever begin
      if (n > 0 && inst_mem_en_o && !prev_ie) break;
      if (halted_o || n >= 64) break;
      iack = inst_mem_en_o ? (icnt == wi) : 1'($urandom);
      dack = (data_mem_rd_en_o || data_mem_wr_en_o) ? (dcnt == wd) : 1'($urandom);
      #1;
      if (inst_mem_en_o) icnt++;
      if (data_mem_rd_en_o || data_mem_wr_en_o) dcnt++;
      rd_c += int'(data_mem_rd_en_o);
      st_c += int'(data_mem_wr_en_o);
      ir_c += int'(ir_en_o);
      mdr_c += int'(mdr_en_o);
      if (pc_en_o) begin
        pc_c++; pcs = int'(pc_src_o);
        a = int'(alu_src_a_o); b = int'(alu_src_b_o); o = int'(alu_op_o); w = int'(alu_32b_o);
      end
      if (wr_reg_en_o) begin wr_c++; wrs = int'(wr_reg_src_o); end
      if (pc_en_o && wr_reg_en_o) both_c++;
      prev_ie = inst_mem_en_o;
      n++;
      @(negedge clk);
      iack = 1'b0; dack = 1'b0;
    end
    if (n >= 64) check("timeout", n, 0);
    else if (e.halts) begin
      check("halt_cycle", n, wi + 2);
      check("illegal_flag", int'(illegal_instruction_o), int'(e.illegal));
      check("halt_pc_en", pc_c, 0);
      check("halt_wr_reg", wr_c, 0);
    end else begin
      check("period", n, e.base + wi + ((e.mem != 0) ? wd : 0));
      check("ir_en_pulses", ir_c, 1);
      check("pc_en_pulses", pc_c, 1);
      check("pc_src", pcs, e.pcsrc);
      check("wr_reg_pulses", wr_c, int'(e.writes));
      if (e.writes) check("wr_reg_src", wrs, e.wsrc);
      check("pc_wr_overlap", both_c, int'(e.writes));
      check("mdr_pulses", mdr_c, (e.mem == 1) ? 1 : 0);
      check("rd_cycles", rd_c, (e.mem == 1) ? wd + 1 : 0);
      check("wr_cycles", st_c, (e.mem == 2) ? wd + 1 : 0);
      check("alu_src_a", a, e.a);
      check("alu_src_b", b, e.b);
      check("alu_op", o, e.op);
      check("alu_32b", w, e.w);
    end
  endtask

  task automatic hold_halt(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      iack = 1'($urandom); dack = 1'($urandom);
      #1;
      check("halt_enables", int'(en_bus), 0);
      check("halted", int'(halted_o), 1);
    end
    iack = 1'b0; dack = 1'b0;
  endtask

  // Ends at the negedge of the first Fetch cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iack = 1'b0; dack = 1'b0;
    #1;
    check("reset_cycle_enables", int'(en_bus), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_outputs", int'({en_bus, pc_src_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                                alu_32b_o, wr_reg_src_o}), 0);
    check("idle_flags", int'({illegal_instruction_o, halted_o}), 0);
    @(negedge clk);
    check("fetch_after_idle", int'(inst_mem_en_o), 1);
  endtask

  task automatic recover();
    if (!inst_mem_en_o) begin
      if (halted_o) hold_halt(2);
      do_reset();
    end
  endtask

  task automatic reset_in_memory();
    int rd_seen = 0;
    opcode = 7'b0000011; funct3 = 3'd3; funct7 = 7'd0; cond = 1'b0;
    for (int i = 0; i < 20 && rd_seen < 3; i++) begin
      iack = inst_mem_en_o; dack = 1'b0;
      #1;
      rd_seen += int'(data_mem_rd_en_o);
      @(negedge clk);
      iack = 1'b0;
    end
    check("mem_wait_reached", rd_seen, 3);
    do_reset();
  endtask

  logic [6:0] ops [13] = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0110111,
                           7'b0010111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                           7'b1100111, 7'b0001111, 7'b1110011};

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; iack = 1'b0; dack = 1'b0; cond = 1'b0;
    do_reset();
    run_instr(7'b0110011, 3'd0, 7'h00, 0, 0, 0);
    run_instr(7'b0110011, 3'd0, 7'h00, 0, 0, 0);
    run_instr(7'b0000011, 3'd3, 7'h00, 0, 3, 0);
    run_instr(7'b1100011, 3'd0, 7'h00, 0, 0, 1);
    run_instr(7'b1100011, 3'd0, 7'h00, 1, 0, 0);
    run_instr(7'b0100011, 3'd3, 7'h00, 2, 1, 0);
    run_instr(7'b1101111, 3'd5, 7'h11, 0, 0, 0);
    run_instr(7'b1100111, 3'd0, 7'h00, 0, 0, 0);
    run_instr(7'b0110111, 3'd1, 7'h00, 0, 0, 0);
    run_instr(7'b0011011, 3'd5, 7'h20, 0, 0, 0);
    run_instr(7'b0000000, 3'd0, 7'h00, 0, 0, 0);
    hold_halt(10);
    recover();
    run_instr(7'b0100011, 3'd4, 7'h00, 1, 0, 0);
    recover();
    run_instr(7'b1110011, 3'd0, 7'h00, 0, 0, 0);
    check("system_halted", int'(halted_o), 1);
    recover();
    run_instr(7'b0011011, 3'd1, 7'h01, 0, 0, 0);
    recover();
    reset_in_memory();
    repeat (80) begin
      logic [6:0] op, f7;
      int r;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 12)];
      r  = $urandom_range(0, 3);
      f7 = (r == 0) ? 7'h20 : (r == 1) ? 7'($urandom) : 7'h00;
      run_instr(op, 3'($urandom), f7, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom));
      recover();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
